// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants for the up/down counter family
package counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  typedef enum logic [0:0] {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/up_down_counter_param_if.sv
// rtl/up_down_counter_param_if.sv - control and status bundle for up_down_counter_param
interface up_down_counter_param_if #(
  parameter int WIDTH = 4
);

  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             zero;

  modport master (
    output en, up_dn, load, load_val,
    input  q, tc, zero
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output q, tc, zero
  );

endinterface

// File: rtl/counter_next_logic.sv
// rtl/counter_next_logic.sv - next-count and terminal-count logic
// Range checks run one bit wider than the count so a step never silently overflows.
module counter_next_logic
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = (2 ** WIDTH) - 1,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             en_i,
  input  logic             up_dn_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] next_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VAL);
  localparam logic [WIDTH:0]   ONE_X    = {{WIDTH{1'b0}}, 1'b1};
  localparam bit               SAT_MODE = (SATURATE == MODE_SAT);

  logic [WIDTH:0] q_x;
  logic [WIDTH:0] max_x;
  logic [WIDTH:0] ld_x;
  logic [WIDTH:0] inc_x;
  logic [WIDTH:0] dec_x;

  assign q_x   = {1'b0, q_i};
  assign max_x = {1'b0, MAX_W};
  assign ld_x  = {1'b0, load_val_i};
  assign inc_x = q_x + ONE_X;
  assign dec_x = q_x - ONE_X;

  always_comb begin
    next_o = q_i;
    if (load_i) begin
      next_o = (ld_x > max_x) ? MAX_W : load_val_i;
    end else if (en_i) begin
      if (up_dn_i == DIR_UP) begin
        if (inc_x > max_x) next_o = SAT_MODE ? MAX_W : '0;
        else               next_o = inc_x[WIDTH-1:0];
      end else begin
        // Borrow out of the wide subtract means we were already at zero.
        if (dec_x[WIDTH]) next_o = SAT_MODE ? '0 : MAX_W;
        else              next_o = dec_x[WIDTH-1:0];
      end
    end
  end

  assign tc_o = en_i & ~load_i &
                ((up_dn_i & (q_i == MAX_W)) | (~up_dn_i & (q_i == '0)));

endmodule

// File: rtl/up_down_counter_param.sv
// rtl/up_down_counter_param.sv - WIDTH-bit up/down counter with modulus, load and wrap/saturate
module up_down_counter_param
  import counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_VAL   = (2 ** WIDTH) - 1,
  parameter int RESET_VAL = 0,
  parameter int SATURATE  = MODE_WRAP
) (
  input logic                    clk,
  input logic                    reset,
  up_down_counter_param_if.slave bus
);

  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             tc;

  counter_next_logic #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAX_VAL),
    .SATURATE (SATURATE)
  ) u_next (
    .q_i        (q_q),
    .en_i       (bus.en),
    .up_dn_i    (bus.up_dn),
    .load_i     (bus.load),
    .load_val_i (bus.load_val),
    .next_o     (q_d),
    .tc_o       (tc)
  );

  always_ff @(posedge clk) begin
    if (!reset) q_q <= RESET_W;
    else        q_q <= q_d;
  end

  assign bus.q    = q_q;
  assign bus.tc   = tc;
  assign bus.zero = (q_q == '0);

endmodule

// File: tb/tb_up_down_counter_param.sv
// tb/tb_up_down_counter_param.sv - scoreboard bench for up_down_counter_param
module tb_up_down_counter_param;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   exp_q[$];

  up_down_counter_param_if #(.WIDTH(4)) if_def ();
  up_down_counter_param_if #(.WIDTH(4)) if_m9 ();
  up_down_counter_param_if #(.WIDTH(4)) if_sat ();
  up_down_counter_param_if #(.WIDTH(4)) if_r3 ();
  up_down_counter_param_if #(.WIDTH(4)) if_lo ();
  up_down_counter_param_if #(.WIDTH(4)) if_hi ();

  up_down_counter_param u_def (.clk(clk), .reset(reset), .bus(if_def));
  up_down_counter_param #(.MAX_VAL(9)) u_m9 (.clk(clk), .reset(reset), .bus(if_m9));
  up_down_counter_param #(.MAX_VAL(9), .SATURATE(1)) u_sat (.clk(clk), .reset(reset), .bus(if_sat));
  up_down_counter_param #(.MAX_VAL(9), .RESET_VAL(3)) u_r3 (.clk(clk), .reset(reset), .bus(if_r3));
  up_down_counter_param u_lo (.clk(clk), .reset(reset), .bus(if_lo));
  up_down_counter_param u_hi (.clk(clk), .reset(reset), .bus(if_hi));

  assign if_hi.en = if_lo.tc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_next(int q, bit en, bit up, bit ld, int lv, int mx, bit sat);
    if (ld) return (lv > mx) ? mx : lv;
    if (!en) return q;
    if (up) begin
      if (sat && q == mx) return mx;
      return (q + 1) % (mx + 1);
    end
    if (sat && q == 0) return 0;
    return (q + mx) % (mx + 1);
  endfunction

  task automatic test_reset();
    int exp;
    @(negedge clk);
    reset = 1'b0;
    if_def.en = 1'b1;
    if_def.up_dn = 1'b0;
    exp_q.push_back(0);
    exp_q.push_back(3);
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++; if (if_def.q !== 4'(exp)) begin failures++; $display("FAIL reset_q actual=%0d expected=%0d", if_def.q, exp); end
    checks++; if (if_def.zero !== 1'b1) begin failures++; $display("FAIL reset_zero actual=%0b expected=1", if_def.zero); end
    checks++; if (if_r3.q !== 4'(exp_q.pop_front())) begin failures++; $display("FAIL reset_val3 actual=%0d expected=3", if_r3.q); end
    reset = 1'b1;
    for (int i = 0; i < 17; i++) begin
      #1;
      checks++; if (if_def.tc !== (exp == 0)) begin failures++; $display("FAIL down_tc step=%0d actual=%0b expected=%0b", i, if_def.tc, exp == 0); end
      exp_q.push_back(model_next(exp, 1, 0, 0, 0, 15, 0));
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++; if (if_def.q !== 4'(exp)) begin failures++; $display("FAIL down_q step=%0d actual=%0d expected=%0d", i, if_def.q, exp); end
    end
    if_def.en = 1'b0;
  endtask

  task automatic test_mod_wrap();
    int cur;
    cur = 0;
    if_m9.en = 1'b1;
    if_m9.up_dn = 1'b1;
    for (int i = 0; i < 11; i++) begin
      #1;
      checks++; if (if_m9.tc !== (cur == 9)) begin failures++; $display("FAIL m9_tc q=%0d actual=%0b expected=%0b", cur, if_m9.tc, cur == 9); end
      checks++; if (if_m9.zero !== (cur == 0)) begin failures++; $display("FAIL m9_zero q=%0d actual=%0b expected=%0b", cur, if_m9.zero, cur == 0); end
      exp_q.push_back(model_next(cur, 1, 1, 0, 0, 9, 0));
      @(negedge clk);
      cur = exp_q.pop_front();
      checks++; if (if_m9.q !== 4'(cur)) begin failures++; $display("FAIL m9_q step=%0d actual=%0d expected=%0d", i, if_m9.q, cur); end
    end
    if_m9.en = 1'b0;
  endtask

  task automatic test_saturate();
    int cur;
    if_sat.load = 1'b1;
    if_sat.load_val = 4'd8;
    exp_q.push_back(8);
    @(negedge clk);
    cur = exp_q.pop_front();
    checks++; if (if_sat.q !== 4'(cur)) begin failures++; $display("FAIL sat_preload actual=%0d expected=%0d", if_sat.q, cur); end
    if_sat.load = 1'b0;
    if_sat.en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if_sat.up_dn = (i < 4);
      #1;
      checks++; if (if_sat.tc !== (if_sat.up_dn && cur == 9)) begin failures++; $display("FAIL sat_tc step=%0d actual=%0b expected=%0b", i, if_sat.tc, if_sat.up_dn && cur == 9); end
      exp_q.push_back(model_next(cur, 1, if_sat.up_dn, 0, 0, 9, 1));
      @(negedge clk);
      cur = exp_q.pop_front();
      checks++; if (if_sat.q !== 4'(cur)) begin failures++; $display("FAIL sat_q step=%0d actual=%0d expected=%0d", i, if_sat.q, cur); end
    end
    if_sat.en = 1'b0;
  endtask

  task automatic test_load();
    int exp;
    if_m9.load = 1'b1;
    if_m9.load_val = 4'd5;
    if_m9.en = 1'b1;
    if_m9.up_dn = 1'b1;
    exp_q.push_back(5);
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++; if (if_m9.q !== 4'(exp)) begin failures++; $display("FAIL load_wins actual=%0d expected=%0d", if_m9.q, exp); end
    if_m9.load_val = 4'd12;
    exp_q.push_back(9);
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++; if (if_m9.q !== 4'(exp)) begin failures++; $display("FAIL load_clamp actual=%0d expected=%0d", if_m9.q, exp); end
    #1;
    checks++; if (if_m9.tc !== 1'b0) begin failures++; $display("FAIL load_gates_tc actual=%0b expected=0", if_m9.tc); end
    if_m9.load = 1'b0;
    #1;
    checks++; if (if_m9.tc !== 1'b1) begin failures++; $display("FAIL tc_at_max actual=%0b expected=1", if_m9.tc); end
    exp_q.push_back(0);
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++; if (if_m9.q !== 4'(exp)) begin failures++; $display("FAIL wrap_after_load actual=%0d expected=%0d", if_m9.q, exp); end
    checks++; if (if_m9.zero !== 1'b1) begin failures++; $display("FAIL zero_after_wrap actual=%0b expected=1", if_m9.zero); end
    if_m9.en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int e0;
    int e3;
    if_m9.load = 1'b1;  if_m9.load_val = 4'd7;
    if_r3.load = 1'b1;  if_r3.load_val = 4'd7;
    exp_q.push_back(7);
    exp_q.push_back(7);
    @(negedge clk);
    e0 = exp_q.pop_front();
    e3 = exp_q.pop_front();
    checks++; if (if_m9.q !== 4'(e0) || if_r3.q !== 4'(e3)) begin failures++; $display("FAIL mid_preload actual=%0d/%0d expected=%0d/%0d", if_m9.q, if_r3.q, e0, e3); end
    reset = 1'b0;
    if_m9.load_val = 4'd2;  if_m9.en = 1'b1;
    if_r3.load_val = 4'd2;  if_r3.en = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(3);
    @(negedge clk);
    reset = 1'b1;
    if_m9.load = 1'b0;  if_m9.en = 1'b0;
    if_r3.load = 1'b0;  if_r3.en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      e0 = exp_q.pop_front();
      e3 = exp_q.pop_front();
      checks++; if (if_m9.q !== 4'(e0)) begin failures++; $display("FAIL mid_reset_q0 cycle=%0d actual=%0d expected=%0d", i, if_m9.q, e0); end
      checks++; if (if_r3.q !== 4'(e3)) begin failures++; $display("FAIL mid_reset_q3 cycle=%0d actual=%0d expected=%0d", i, if_r3.q, e3); end
      if (i < 5) begin
        exp_q.push_back(model_next(e0, 0, 0, 0, 0, 9, 0));
        exp_q.push_back(model_next(e3, 0, 0, 0, 0, 9, 0));
        @(negedge clk);
      end
    end
  endtask

  task automatic test_cascade();
    int lo_c;
    int hi_c;
    lo_c = 0;
    hi_c = 0;
    if_lo.up_dn = 1'b1;
    if_hi.up_dn = 1'b1;
    if_lo.en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++; if (if_hi.en !== (lo_c == 15)) begin failures++; $display("FAIL cascade_tc step=%0d actual=%0b expected=%0b", i, if_hi.en, lo_c == 15); end
      exp_q.push_back(model_next(lo_c, 1, 1, 0, 0, 15, 0));
      exp_q.push_back(model_next(hi_c, lo_c == 15, 1, 0, 0, 15, 0));
      @(negedge clk);
      lo_c = exp_q.pop_front();
      hi_c = exp_q.pop_front();
      checks++; if (if_lo.q !== 4'(lo_c) || if_hi.q !== 4'(hi_c)) begin failures++; $display("FAIL cascade_q step=%0d actual=%0d/%0d expected=%0d/%0d", i, if_hi.q, if_lo.q, hi_c, lo_c); end
    end
    checks++; if (if_hi.q !== 4'd1 || if_lo.q !== 4'd0) begin failures++; $display("FAIL cascade_final actual=%0d/%0d expected=1/0", if_hi.q, if_lo.q); end
    if_lo.en = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    if_def.en = 1'b0; if_def.up_dn = 1'b0; if_def.load = 1'b0; if_def.load_val = '0;
    if_m9.en  = 1'b0; if_m9.up_dn  = 1'b0; if_m9.load  = 1'b0; if_m9.load_val  = '0;
    if_sat.en = 1'b0; if_sat.up_dn = 1'b0; if_sat.load = 1'b0; if_sat.load_val = '0;
    if_r3.en  = 1'b0; if_r3.up_dn  = 1'b0; if_r3.load  = 1'b0; if_r3.load_val  = '0;
    if_lo.en  = 1'b0; if_lo.up_dn  = 1'b0; if_lo.load  = 1'b0; if_lo.load_val  = '0;
    if_hi.up_dn = 1'b0; if_hi.load = 1'b0; if_hi.load_val = '0;

    test_reset();
    test_mod_wrap();
    test_saturate();
    test_load();
    test_reset_mid();
    test_cascade();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/up_down_counter_param.md
Name: up_down_counter_param

Overview:
- Parametrised successor of the team's fixed 4-bit down counter: a WIDTH-bit up/down counter with programmable modulus, parallel load, count enable and a wrap or saturate mode.
- Used as a general timer, divider and sequencer primitive in lab datapaths.
- Flags terminal count so it can be cascaded, and flags zero.

Parameters:
- WIDTH, 4, counter width in bits (≥1).
- MAX_VAL, 2**WIDTH-1, highest count value (1 ≤ MAX_VAL ≤ 2**WIDTH-1); count range is 0..MAX_VAL.
- RESET_VAL, 0, value of q after reset (must be ≤ MAX_VAL).
- SATURATE, 0, 0 = wrap at the range ends; 1 = hold at the range ends.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- en  input  1  count enable.
- up_dn  input  1  direction: 1 = count up, 0 = count down.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value to load.
- q  output  WIDTH  registered count.
- tc  output  1  terminal count, combinational.
- zero  output  1  high when q == 0, combinational from q.

Behaviour:
- Priority on each rising edge: reset low > load > en > hold.
- Reset (reset==0 at the edge): q <= RESET_VAL. Reset asserted mid-count overrides load and en in that same cycle. After release, counting resumes on the first edge with en=1.
- Load (reset==1, load==1): q <= min(load_val, MAX_VAL). An out-of-range load clamps to MAX_VAL. en and up_dn are ignored in that cycle.
- Count (reset==1, load==0, en==1):
  - Up: if q < MAX_VAL, q <= q+1. Otherwise q <= 0 (SATURATE=0) or q holds at MAX_VAL (SATURATE=1).
  - Down: if q > 0, q <= q-1. Otherwise q <= MAX_VAL (SATURATE=0) or q holds at 0 (SATURATE=1).
- Hold: en==0 keeps q unchanged.
- Arithmetic: all arithmetic is done at WIDTH+1 bits internally, so no implicit overflow ever occurs. Values above MAX_VAL are never produced.
- tc = en & ~load & ((up_dn & q==MAX_VAL) | (~up_dn & q==0)).
  - Goes high in the cycle before the wrap/hold edge.
  - Asserted in both modes, so it can drive the en of the next cascaded stage.
  - Not gated by reset, but q is defined from the first reset edge.
- Latency: one clock from input change to q change.
- Direction may change on any cycle; the new direction takes effect on that edge with no extra delay.
- Outputs before the first reset edge are undefined. The bench must apply reset first.

Decomposition:
- Shared package counter_pkg holds:
  - the mode constants MODE_WRAP=0 and MODE_SAT=1;
  - the direction constants DIR_DOWN=0 and DIR_UP=1.
- Optional sub-module counter_next_logic (combinational):
  - inputs: q, en, up_dn, load, load_val;
  - outputs: next value and tc.
  - The top level keeps the register, reset handling and zero flag.

Test Plan:
- Defaults (WIDTH=4, wrap): reset=0 for one edge, then reset=1, en=1, up_dn=0. Required: q=0 after reset, then 15,14,…,0,15. tc high exactly while q==0.
- MAX_VAL=9, up, wrap: q runs 0,1,…,9,0. tc high only at q==9. zero high only at q==0.
- SATURATE=1, MAX_VAL=9, up from 8: q=9 and then stays 9 with tc held high. Switch up_dn=0: q goes 8,7 immediately.
- Load checks: load=1 with load_val=5 and en=1 gives q=5 next cycle (load wins). load_val=12 with MAX_VAL=9 gives q=9 (clamp).
- Reset mid-count: drive reset=0 with load=1 and en=1 while q=7. Required: q=RESET_VAL next edge (also test RESET_VAL=3 gives 3). Holding en=0 afterwards keeps q constant over 5 cycles.
- Cascade: two WIDTH=4 instances with tc of the low stage driving en of the high stage, both counting up. After 16 low-stage counts the high stage reads 1 and the low stage reads 0.
